// File: rtl/lshift_seq_pkg.sv
// shift_pkg: shared constants and types for the iterative left shifter.
//   DATA_W / AMT_W : operand width (8) and shift-amount width (3)
//   state_e        : FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//   MODE_LSL/ROL   : mode select values (logical shift / rotate)
package shift_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic MODE_LSL = 1'b0;
  localparam logic MODE_ROL = 1'b1;

endpackage

// File: rtl/lshift_seq_if.sv
// lshift_seq_if: start/done handshake and result bus of the shifter.
//   master : drives start, ip, s, mode; observes out, carry, zero, busy, done
//   slave  : the shifter side (inverse directions)
interface lshift_seq_if;
  import shift_pkg::*;

  logic              start;
  logic [DATA_W-1:0] ip;
  logic [AMT_W-1:0]  s;
  logic              mode;
  logic [DATA_W-1:0] out;
  logic              carry;
  logic              zero;
  logic              busy;
  logic              done;

  modport master (output start, ip, s, mode,
                  input  out, carry, zero, busy, done);

  modport slave  (input  start, ip, s, mode,
                  output out, carry, zero, busy, done);

endinterface

// File: rtl/lshift_seq_step.sv
// lshift_step: one-position combinational left shift or rotate.
//   val_i  : value to shift
//   mode_i : MODE_LSL fills bit 0 with 0, MODE_ROL feeds bit 7 back in
//   val_o  : shifted value
//   cout_o : bit shifted out of position 7
module lshift_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] val_i,
  input  logic              mode_i,
  output logic [DATA_W-1:0] val_o,
  output logic              cout_o
);

  logic fill;

  assign fill   = (mode_i == MODE_ROL) ? val_i[DATA_W-1] : 1'b0;
  assign val_o  = {val_i[DATA_W-2:0], fill};
  assign cout_o = val_i[DATA_W-1];

endmodule

// File: rtl/lshift_seq.sv
// lshift_seq: iterative 8-bit left shifter/rotator, one bit per clock.
//   clk : system clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : slave side of lshift_seq_if (start/ip/s/mode in;
//         out/carry/zero/busy/done out, all registered)
module lshift_seq
  import shift_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  lshift_seq_if.slave  bus
);

  state_e             state_q;
  logic [DATA_W-1:0]  work_q;
  logic               c_work_q;
  logic [AMT_W-1:0]   cnt_q;
  logic               mode_q;
  logic [DATA_W-1:0]  out_q;
  logic               carry_q;
  logic               zero_q;
  logic               busy_q;
  logic               done_q;

  logic [DATA_W-1:0]  step_val;
  logic               step_cout;
  logic [DATA_W-1:0]  result_d;
  logic               carry_d;

  lshift_step u_step (
    .val_i  (work_q),
    .mode_i (mode_q),
    .val_o  (step_val),
    .cout_o (step_cout)
  );

  // A zero shift amount still spends one cycle in SHIFT without moving the
  // data, so the minimum latency is one edge like a one-bit shift.
  always_comb begin
    result_d = work_q;
    carry_d  = c_work_q;
    if (cnt_q != '0) begin
      result_d = step_val;
      carry_d  = step_cout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      c_work_q <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= MODE_LSL;
      out_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            work_q   <= bus.ip;
            cnt_q    <= bus.s;
            mode_q   <= bus.mode;
            c_work_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q != '0) begin
            work_q   <= step_val;
            c_work_q <= step_cout;
            cnt_q    <= cnt_q - 1'b1;
          end
          if (cnt_q <= AMT_W'(1)) begin
            out_q   <= result_d;
            carry_q <= carry_d;
            zero_q  <= (result_d == '0);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out   = out_q;
  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_lshift_seq.sv
module tb_lshift_seq;

  typedef struct {
    logic [7:0] out;
    logic       carry;
    logic       zero;
    int         lat;
  } exp_t;

  logic clk;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   done_cnt     = 0;
  exp_t sb[$];

  lshift_seq_if bus ();

  lshift_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input int sh, input logic m);
    exp_t e;
    logic [7:0] v;
    logic c;
    v = a;
    c = 1'b0;
    for (int i = 0; i < sh; i++) begin
      c = v[7];
      v = {v[6:0], (m ? v[7] : 1'b0)};
    end
    e.out   = v;
    e.carry = c;
    e.zero  = (v == 8'h00);
    e.lat   = (sh == 0) ? 1 : sh;
    return e;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [2:0] sh, input logic m,
                        input int inject_at);
    exp_t e;
    exp_t got;
    logic [7:0] prev;
    int k;
    int dc0;
    bit seen;
    e = model(a, int'(sh), m);
    sb.push_back(e);
    prev = bus.out;
    dc0  = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.ip = a; bus.s = sh; bus.mode = m;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.ip = ~a; bus.s = sh + 3'd1; bus.mode = ~m;
    k = 0;
    seen = 0;
    while (!seen && k < 20) begin
      if (bus.done === 1'b1) begin
        seen = 1;
      end else begin
        chk("busy_during_op", bus.busy, 1);
        chk("out_hold", bus.out, prev);
        if (k == inject_at) begin
          bus.start = 1'b1; bus.ip = 8'hFF; bus.s = 3'd2; bus.mode = 1'b0;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    bus.start = 1'b0;
    got = sb.pop_front();
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("latency", k, got.lat);
      chk("out", bus.out, got.out);
      chk("carry", bus.carry, got.carry);
      chk("zero", bus.zero, got.zero);
      chk("busy_at_done", bus.busy, 1);
    end
    @(negedge clk);
    chk("busy_after", bus.busy, 0);
    chk("done_after", bus.done, 0);
    chk("done_pulses", done_cnt - dc0, 1);
  endtask

  initial begin
    logic [7:0] prev;
    int dc0;
    rst = 1'b1;
    bus.start = 1'b0; bus.ip = 8'h00; bus.s = 3'd0; bus.mode = 1'b0;
    #12;
    chk("rst_out", bus.out, 8'h00);
    chk("rst_carry", bus.carry, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h81, 3'd1, 1'b0, -1);
    run_op(8'h81, 3'd3, 1'b1, -1);
    run_op(8'h5A, 3'd0, 1'b0, -1);
    run_op(8'hF0, 3'd4, 1'b0, -1);
    run_op(8'h01, 3'd7, 1'b0, 2);
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", bus.busy, 0);
    chk("ignored_start_out", bus.out, 8'h80);

    // reset in the middle of a shift
    prev = bus.out;
    @(negedge clk);
    bus.start = 1'b1; bus.ip = 8'hA5; bus.s = 3'd6; bus.mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    chk("pre_rst_out", bus.out, prev);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", bus.out, 8'h00);
    chk("mid_rst_zero", bus.zero, 1);
    chk("mid_rst_carry", bus.carry, 0);
    chk("mid_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    dc0 = done_cnt;
    repeat (8) @(negedge clk);
    chk("no_done_after_rst", done_cnt - dc0, 0);
    chk("idle_after_rst", bus.busy, 0);
    chk("out_after_rst", bus.out, 8'h00);

    run_op(8'h03, 3'd2, 1'b0, -1);
    chk("post_rst_result", bus.out, 8'h0C);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] a;
      logic [2:0] sh;
      logic m;
      a  = 8'($urandom_range(0, 255));
      sh = 3'($urandom_range(0, 7));
      m  = 1'($urandom_range(0, 1));
      run_op(a, sh, m, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
